// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register family.
//   - Stop/NoStop encodings of a stall-vector bit
//   - RstEnable: level of the active-low reset when asserted
//   - ZeroWord: all-zero 32-bit word
//   - Default stall-vector indices for each pipeline stage
//   - stage_action(): resolves flush/stall bits into one register action
package pipe_stage_reg_pkg;

  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic        RstEnable = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Stall bit 0 belongs to the PC; the latches follow in pipeline order.
  localparam int StageIf  = 1;
  localparam int StageId  = 2;
  localparam int StageEx  = 3;
  localparam int StageMem = 4;
  localparam int StageWb  = 5;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_ADVANCE = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_act_e;

  // Priority: flush > bubble > advance > hold. A stalled stage whose
  // downstream neighbour keeps running must emit a NOP (bubble).
  function automatic stage_act_e stage_action(input logic flush_i,
                                              input logic stall_here,
                                              input logic stall_down);
    stage_act_e act;
    if (flush_i) begin
      act = ACT_FLUSH;
    end else if (stall_here == NoStop) begin
      act = ACT_ADVANCE;
    end else if (stall_down == NoStop) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_lane_popcount.sv
// lane_popcount: combinational count of set bits in a lane-valid vector.
//   lanes : LANES-bit valid vector
//   count : number of set bits, OUT_W = $clog2(LANES+1) bits wide
module lane_popcount #(
  parameter int LANES = 1,
  parameter int OUT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] lanes,
  output logic [OUT_W-1:0] count
);

  // Ripple sum of lane bits; LANES is at most 4 so depth stays shallow.
  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + OUT_W'(lanes[i]);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-lane pipeline latch between two adjacent stages,
// obeying the core's stall vector and flush, with a retire counter of valid
// lanes advanced into the output.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   stall      : stall vector, bit STAGE is this latch, STAGE+1 downstream
//   flush      : clears this stage (beats any stall)
//   in_valid   : per-lane valid from upstream
//   in_data    : lane payloads, lane i at [i*DATA_W +: DATA_W]
//   out_valid  : registered per-lane valid
//   out_data   : registered lane payloads
//   retire_clr : synchronous clear of retire_cnt (beats increment)
//   retire_cnt : modulo-2^CNT_W count of valid lanes advanced
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int LANES          = 1,
  parameter int STAGE          = 4,
  parameter int STALL_W        = 6,
  parameter int ZERO_ON_BUBBLE = 1,
  parameter int CNT_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      retire_clr,
  output logic [CNT_W-1:0]          retire_cnt
);

  localparam int PC_W = $clog2(LANES + 1);

  stage_act_e                act;
  logic [PC_W-1:0]           in_pop;
  logic [LANES-1:0]          valid_d, valid_q;
  logic [LANES*DATA_W-1:0]   data_d, data_q;
  logic [CNT_W-1:0]          cnt_d, cnt_q;

  // Only two stall bits matter here; the rest belong to other stages.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  lane_popcount #(
    .LANES (LANES),
    .OUT_W (PC_W)
  ) u_lane_popcount (
    .lanes (in_valid),
    .count (in_pop)
  );

  // Next-state selection for valid, payload and retire counter.
  always_comb begin
    act     = stage_action(flush, stall[STAGE], stall[STAGE+1]);
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = '0;
        if (ZERO_ON_BUBBLE != 0) begin
          data_d = '0;
        end else begin
          data_d = data_q;
        end
      end
      ACT_ADVANCE: begin
        // All lanes move together; invalid lanes still load their payload.
        valid_d = in_valid;
        data_d  = in_data;
        cnt_d   = cnt_q + CNT_W'(in_pop);
      end
      ACT_HOLD: begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
      end
      default: begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
      end
    endcase
    // Clear overrides a same-cycle increment.
    if (retire_clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. Two instances:
//   dut_a : LANES=2, DATA_W=32, ZERO_ON_BUBBLE=1, CNT_W=32
//   dut_b : LANES=2, DATA_W=32, ZERO_ON_BUBBLE=0, CNT_W=4
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic [1:0]  in_valid_a, in_valid_b;
  logic [63:0] in_data_a, in_data_b;
  logic [1:0]  out_valid_a, out_valid_b;
  logic [63:0] out_data_a, out_data_b;
  logic        clr_a, clr_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks;
  int errors;

  pipe_stage_reg #(
    .DATA_W(32), .LANES(2), .STAGE(4), .STALL_W(6), .ZERO_ON_BUBBLE(1), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .stall(stall_a), .flush(flush_a),
    .in_valid(in_valid_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_data(out_data_a),
    .retire_clr(clr_a), .retire_cnt(cnt_a)
  );

  pipe_stage_reg #(
    .DATA_W(32), .LANES(2), .STAGE(4), .STALL_W(6), .ZERO_ON_BUBBLE(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .stall(stall_b), .flush(flush_b),
    .in_valid(in_valid_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_data(out_data_b),
    .retire_clr(clr_b), .retire_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall_a = 6'b0; flush_a = 1'b0; in_valid_a = 2'b00; in_data_a = 64'h0; clr_a = 1'b0;
    stall_b = 6'b0; flush_b = 1'b0; in_valid_b = 2'b00; in_data_b = 64'h0; clr_b = 1'b0;
    #2;
    checks++; if (out_valid_a !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", out_valid_a); end
    checks++; if (out_data_a !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data_a); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_a); end
    #1 rst = 1'b1;
  endtask

  task automatic test_reset_midop();
    stall_a = 6'b0; in_valid_a = 2'b11; in_data_a = {32'hDEAD_BEEF, 32'h1234_5678};
    tick();
    checks++; if (out_valid_a !== 2'b11) begin errors++; $display("FAIL midop_valid got %b want 11", out_valid_a); end
    checks++; if (out_data_a !== 64'hDEAD_BEEF_1234_5678) begin errors++; $display("FAIL midop_data got %h want deadbeef12345678", out_data_a); end
    checks++; if (cnt_a !== 32'd2) begin errors++; $display("FAIL midop_cnt1 got %0d want 2", cnt_a); end
    tick();
    tick();
    checks++; if (cnt_a !== 32'd6) begin errors++; $display("FAIL midop_cnt3 got %0d want 6", cnt_a); end
    // Hold the stage, then assert reset between edges.
    stall_a = 6'b111111;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid_a !== 2'b00) begin errors++; $display("FAIL async_rst_valid got %b want 00", out_valid_a); end
    checks++; if (out_data_a !== 64'h0) begin errors++; $display("FAIL async_rst_data got %h want 0", out_data_a); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL async_rst_cnt got %0d want 0", cnt_a); end
    checks++; if (out_valid_b !== 2'b00) begin errors++; $display("FAIL async_rst_valid_b got %b want 00", out_valid_b); end
    #1 rst = 1'b1;
    stall_a = 6'b0; in_valid_a = 2'b00; in_data_a = 64'h0;
  endtask

  task automatic test_bubble();
    in_valid_a = 2'b01; in_data_a = {32'hAAAA_0001, 32'hBBBB_0002};
    tick();
    checks++; if (cnt_a !== 32'd1) begin errors++; $display("FAIL bubble_pre_cnt got %0d want 1", cnt_a); end
    stall_a = 6'b011111; in_valid_a = 2'b11; in_data_a = {32'h1111_1111, 32'h2222_2222};
    tick();
    checks++; if (out_valid_a !== 2'b00) begin errors++; $display("FAIL bubble_valid got %b want 00", out_valid_a); end
    checks++; if (out_data_a !== 64'h0) begin errors++; $display("FAIL bubble_data got %h want 0", out_data_a); end
    checks++; if (cnt_a !== 32'd1) begin errors++; $display("FAIL bubble_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_hold();
    stall_a = 6'b0; in_valid_a = 2'b11; in_data_a = {32'h1111_1111, 32'h2222_2222};
    tick();
    checks++; if (cnt_a !== 32'd3) begin errors++; $display("FAIL hold_pre_cnt got %0d want 3", cnt_a); end
    stall_a = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      in_data_a = 64'hF0F0_0000_0F0F_0000 ^ 64'(i + 1);
      in_valid_a = 2'(i);
      tick();
      checks++; if (out_valid_a !== 2'b11) begin errors++; $display("FAIL hold_valid[%0d] got %b want 11", i, out_valid_a); end
      checks++; if (out_data_a !== 64'h1111_1111_2222_2222) begin errors++; $display("FAIL hold_data[%0d] got %h want 1111111122222222", i, out_data_a); end
      checks++; if (cnt_a !== 32'd3) begin errors++; $display("FAIL hold_cnt[%0d] got %0d want 3", i, cnt_a); end
    end
  endtask

  task automatic test_partial();
    stall_a = 6'b0; in_valid_a = 2'b10; in_data_a = {32'hCAFE_0001, 32'h0BAD_0002};
    tick();
    checks++; if (out_valid_a !== 2'b10) begin errors++; $display("FAIL partial_valid got %b want 10", out_valid_a); end
    checks++; if (out_data_a !== 64'hCAFE_0001_0BAD_0002) begin errors++; $display("FAIL partial_data got %h want cafe00010bad0002", out_data_a); end
    checks++; if (cnt_a !== 32'd4) begin errors++; $display("FAIL partial_cnt got %0d want 4", cnt_a); end
  endtask

  task automatic test_flush_priority();
    // ZERO_ON_BUBBLE=1 instance: flush zeroes payload even under full stall.
    flush_a = 1'b1; stall_a = 6'b111111; in_valid_a = 2'b11;
    tick();
    checks++; if (out_valid_a !== 2'b00) begin errors++; $display("FAIL flush_a_valid got %b want 00", out_valid_a); end
    checks++; if (out_data_a !== 64'h0) begin errors++; $display("FAIL flush_a_data got %h want 0", out_data_a); end
    checks++; if (cnt_a !== 32'd4) begin errors++; $display("FAIL flush_a_cnt got %0d want 4", cnt_a); end
    flush_a = 1'b0; stall_a = 6'b0;
    // ZERO_ON_BUBBLE=0 instance: payload retained.
    stall_b = 6'b0; in_valid_b = 2'b11; in_data_b = {32'hAAAA_5555, 32'h5555_AAAA};
    tick();
    checks++; if (out_valid_b !== 2'b11) begin errors++; $display("FAIL flush_b_pre_valid got %b want 11", out_valid_b); end
    checks++; if (cnt_b !== 4'd2) begin errors++; $display("FAIL flush_b_pre_cnt got %0d want 2", cnt_b); end
    flush_b = 1'b1; stall_b = 6'b111111; in_data_b = 64'h0123_4567_89AB_CDEF;
    tick();
    checks++; if (out_valid_b !== 2'b00) begin errors++; $display("FAIL flush_b_valid got %b want 00", out_valid_b); end
    checks++; if (out_data_b !== 64'hAAAA_5555_5555_AAAA) begin errors++; $display("FAIL flush_b_data got %h want aaaa55555555aaaa", out_data_b); end
    checks++; if (cnt_b !== 4'd2) begin errors++; $display("FAIL flush_b_cnt got %0d want 2", cnt_b); end
    flush_b = 1'b0;
    // Bubble on the non-zeroing instance also keeps payload.
    stall_b = 6'b011111;
    tick();
    checks++; if (out_data_b !== 64'hAAAA_5555_5555_AAAA) begin errors++; $display("FAIL bubble_b_data got %h want aaaa55555555aaaa", out_data_b); end
  endtask

  task automatic test_wrap_clear();
    logic [3:0] exp_seq [8];
    exp_seq = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0};
    // Clear under hold to start from zero.
    clr_b = 1'b1; stall_b = 6'b111111;
    tick();
    checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL clr_hold_cnt got %0d want 0", cnt_b); end
    clr_b = 1'b0; stall_b = 6'b0; in_valid_b = 2'b11;
    for (int i = 0; i < 8; i++) begin
      in_data_b = 64'(i);
      tick();
      checks++; if (cnt_b !== exp_seq[i]) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, cnt_b, exp_seq[i]); end
    end
    tick();
    checks++; if (cnt_b !== 4'd2) begin errors++; $display("FAIL wrap_cnt_post got %0d want 2", cnt_b); end
    clr_b = 1'b1; in_valid_b = 2'b01; in_data_b = 64'h0000_0007_0000_0008;
    tick();
    checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL clr_adv_cnt got %0d want 0", cnt_b); end
    checks++; if (out_valid_b !== 2'b01) begin errors++; $display("FAIL clr_adv_valid got %b want 01", out_valid_b); end
    checks++; if (out_data_b !== 64'h0000_0007_0000_0008) begin errors++; $display("FAIL clr_adv_data got %h want 0000000700000008", out_data_b); end
    clr_b = 1'b0;
    tick();
    checks++; if (cnt_b !== 4'd1) begin errors++; $display("FAIL after_clr_cnt got %0d want 1", cnt_b); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_midop();
    test_bubble();
    test_hold();
    test_partial();
    test_flush_priority();
    test_wrap_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
